// File: rtl/obstacle_tracker.sv
// obstacle_tracker: fixed table of live obstacles fed by the spawner.
// New obstacles enter at the right edge, shift left by STEP per frame tick,
// retire when they would leave the screen, and are streamed to the drawer
// one beat per live slot over a valid/ready handshake when a redraw is requested.
//
// Ports:
//   clk, reset (async, active low), enable (low freezes all state)
//   frame_tick, spawn/spawn_y, draw_start  - event inputs
//   obj_valid/obj_ready/obj_x/obj_y        - obstacle stream to the drawer
//   scan_done, active_count, busy          - status
// Optional feature (macro OBSTACLE_OVF_CNT_EN): adds ovf_count[7:0]
// (saturating count of spawns dropped on a full table) and ovf_pulse.
module obstacle_tracker #(
    parameter int unsigned SLOTS    = 4,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned Y_MAX    = 119,
    parameter int unsigned STEP     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       spawn,
    input  logic [9:0] spawn_y,
    input  logic       draw_start,
    output logic       obj_valid,
    input  logic       obj_ready,
    output logic [7:0] obj_x,
    output logic [9:0] obj_y,
    output logic       scan_done,
    output logic [4:0] active_count,
    output logic       busy
`ifdef OBSTACLE_OVF_CNT_EN
    ,
    output logic [7:0] ovf_count,
    output logic       ovf_pulse
`endif
);

    localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned CNT_W = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
    localparam logic [X_W-1:0]   X_START  = X_W'(SCREEN_W - 1);
    localparam logic [X_W-1:0]   X_STEP   = X_W'(STEP);
    localparam logic [Y_W-1:0]   Y_CLAMP  = Y_W'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_SCAN,
        S_SCAN_OUT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;

    logic [SLOTS-1:0] slot_active;
    logic [X_W-1:0]   slot_x [SLOTS];
    logic [Y_W-1:0]   slot_y [SLOTS];

    logic             spawn_prev;
    logic             spawn_pend;
    logic             tick_pend;
    logic             draw_pend;
    logic [Y_W-1:0]   pend_y;
    logic             spawn_edge;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    logic take_tick;
    logic take_spawn;
    logic take_draw;
    logic move_en;
    logic scan_load;
    logic scan_skip;
    logic scan_finish;
    logic out_accept;

    assign spawn_edge = spawn & ~spawn_prev;

    // Lowest-index free slot
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (!free_found && !slot_active[IDX_W'(i)]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // State register; busy mirrors the registered state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
        end
    end

    // Next-state and per-cycle action strobes
    always_comb begin
        state_next  = state;
        take_tick   = 1'b0;
        take_spawn  = 1'b0;
        take_draw   = 1'b0;
        move_en     = 1'b0;
        scan_load   = 1'b0;
        scan_skip   = 1'b0;
        scan_finish = 1'b0;
        out_accept  = 1'b0;
        if (enable) begin
            case (state)
                S_IDLE: begin
                    if (tick_pend) begin
                        take_tick  = 1'b1;
                        state_next = S_MOVE;
                    end else if (spawn_pend) begin
                        take_spawn = 1'b1;
                    end else if (draw_pend) begin
                        take_draw  = 1'b1;
                        state_next = S_SCAN;
                    end
                end
                S_MOVE: begin
                    move_en = 1'b1;
                    if (idx == LAST_IDX) state_next = S_IDLE;
                end
                S_SCAN: begin
                    if (slot_active[idx]) begin
                        scan_load  = 1'b1;
                        state_next = S_SCAN_OUT;
                    end else if (idx == LAST_IDX) begin
                        scan_finish = 1'b1;
                        state_next  = S_IDLE;
                    end else begin
                        scan_skip = 1'b1;
                    end
                end
                S_SCAN_OUT: begin
                    if (obj_ready) begin
                        out_accept = 1'b1;
                        if (idx == LAST_IDX) begin
                            scan_finish = 1'b1;
                            state_next  = S_IDLE;
                        end else begin
                            state_next = S_SCAN;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Event capture, slot table, scan index and stream outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spawn_prev   <= 1'b0;
            spawn_pend   <= 1'b0;
            tick_pend    <= 1'b0;
            draw_pend    <= 1'b0;
            pend_y       <= '0;
            idx          <= '0;
            slot_active  <= '0;
            slot_x       <= '{default: '0};
            slot_y       <= '{default: '0};
            obj_valid    <= 1'b0;
            obj_x        <= '0;
            obj_y        <= '0;
            scan_done    <= 1'b0;
            active_count <= '0;
`ifdef OBSTACLE_OVF_CNT_EN
            ovf_count    <= '0;
            ovf_pulse    <= 1'b0;
`endif
        end else begin
            // Edge tracking continues while frozen so a level held across
            // enable is not mistaken for a fresh spawn request.
            spawn_prev <= spawn;
            if (enable) begin
                // A new event in the consuming cycle keeps its flag set
                spawn_pend <= (spawn_pend & ~take_spawn) | spawn_edge;
                tick_pend  <= (tick_pend & ~take_tick) | frame_tick;
                draw_pend  <= (draw_pend & ~take_draw) | draw_start;
                if (spawn_edge) begin
                    pend_y <= (spawn_y > Y_CLAMP) ? Y_CLAMP : spawn_y;
                end

                scan_done <= scan_finish;

                if (take_tick || take_draw) begin
                    idx <= '0;
                end else if (move_en || scan_skip || out_accept) begin
                    idx <= idx + IDX_W'(1);
                end

                if (take_spawn && free_found) begin
                    slot_active[free_idx] <= 1'b1;
                    slot_x[free_idx]      <= X_START;
                    slot_y[free_idx]      <= pend_y;
                    active_count          <= active_count + CNT_W'(1);
                end

                if (move_en && slot_active[idx]) begin
                    if (slot_x[idx] < X_STEP) begin
                        slot_active[idx] <= 1'b0;
                        active_count     <= active_count - CNT_W'(1);
                    end else begin
                        slot_x[idx] <= slot_x[idx] - X_STEP;
                    end
                end

                if (scan_load) begin
                    obj_valid <= 1'b1;
                    obj_x     <= slot_x[idx];
                    obj_y     <= slot_y[idx];
                end else if (out_accept) begin
                    obj_valid <= 1'b0;
                end

`ifdef OBSTACLE_OVF_CNT_EN
                ovf_pulse <= take_spawn & ~free_found;
                if (take_spawn && !free_found && (ovf_count != 8'hFF)) begin
                    ovf_count <= ovf_count + 8'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_obstacle_tracker.sv
// Self-checking bench for obstacle_tracker: directed scenarios plus a random
// mix of spawns, frame ticks and stalled redraws, checked against a slot-table
// model. Define OBSTACLE_OVF_CNT_EN to also check the overflow counter.
`timescale 1ns/1ps
module tb_obstacle_tracker;

    localparam int SLOTS    = 4;
    localparam int SCREEN_W = 160;
    localparam int Y_MAX    = 119;
    localparam int STEP     = 1;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic       spawn;
    logic [9:0] spawn_y;
    logic       draw_start;
    logic       obj_valid;
    logic       obj_ready;
    logic [7:0] obj_x;
    logic [9:0] obj_y;
    logic       scan_done;
    logic [4:0] active_count;
    logic       busy;
`ifdef OBSTACLE_OVF_CNT_EN
    logic [7:0] ovf_count;
    logic       ovf_pulse;
`endif

    obstacle_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .spawn        (spawn),
        .spawn_y      (spawn_y),
        .draw_start   (draw_start),
        .obj_valid    (obj_valid),
        .obj_ready    (obj_ready),
        .obj_x        (obj_x),
        .obj_y        (obj_y),
        .scan_done    (scan_done),
        .active_count (active_count),
        .busy         (busy)
`ifdef OBSTACLE_OVF_CNT_EN
        ,
        .ovf_count    (ovf_count),
        .ovf_pulse    (ovf_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the obstacle table as plain arrays
    bit m_act [SLOTS];
    int m_x   [SLOTS];
    int m_y   [SLOTS];
    int m_ovf;
    int m_drops_total = 0;
    int pulse_seen    = 0;

`ifdef OBSTACLE_OVF_CNT_EN
    always @(negedge clk) if (reset && ovf_pulse) pulse_seen++;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SLOTS; s++) begin
            m_act[s] = 1'b0;
            m_x[s]   = 0;
            m_y[s]   = 0;
        end
        m_ovf = 0;
    endfunction

    function automatic void model_spawn(input int y);
        int yc;
        yc = (y > Y_MAX) ? Y_MAX : y;
        for (int s = 0; s < SLOTS; s++) begin
            if (!m_act[s]) begin
                m_act[s] = 1'b1;
                m_x[s]   = SCREEN_W - 1;
                m_y[s]   = yc;
                return;
            end
        end
        m_drops_total++;
        if (m_ovf < 255) m_ovf++;
    endfunction

    function automatic void model_tick();
        for (int s = 0; s < SLOTS; s++) begin
            if (m_act[s]) begin
                if (m_x[s] < STEP) m_act[s] = 1'b0;
                else               m_x[s]   = m_x[s] - STEP;
            end
        end
    endfunction

    function automatic int model_count();
        int n;
        n = 0;
        for (int s = 0; s < SLOTS; s++) if (m_act[s]) n++;
        return n;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(obj_valid), 0);
        check({tag, "_x"},     32'(obj_x), 0);
        check({tag, "_y"},     32'(obj_y), 0);
        check({tag, "_done"},  32'(scan_done), 0);
        check({tag, "_count"}, 32'(active_count), 0);
        check({tag, "_busy"},  32'(busy), 0);
`ifdef OBSTACLE_OVF_CNT_EN
        check({tag, "_ovf"},   32'(ovf_count), 0);
        check({tag, "_pulse"}, 32'(ovf_pulse), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Count cycles busy stays high for one MOVE pass
    task automatic wait_move();
        int n;
        int w;
        n = 0;
        w = 0;
        while (!busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("move_cycles", 32'(n), 32'(SLOTS));
    endtask

    task automatic do_spawn(input int y, input int hold);
        spawn_y = 10'(y);
        spawn   = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            spawn_y = 10'($urandom_range(0, 1023));
        end
        spawn = 1'b0;
        @(negedge clk);
        model_spawn(y);
        check("count_after_spawn", 32'(active_count), 32'(model_count()));
`ifdef OBSTACLE_OVF_CNT_EN
        check("ovf_count", 32'(ovf_count), 32'(m_ovf));
`endif
        @(negedge clk);
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_move();
        model_tick();
        check("count_after_tick", 32'(active_count), 32'(model_count()));
    endtask

    // Redraw: first beat stalled for 'stall' cycles (0 = random ready);
    // optionally a frame tick is injected while the scan is running.
    task automatic do_draw(input int stall, input bit inject_tick);
        int ex [SLOTS];
        int ey [SLOTS];
        int exp_n;
        int got_n;
        int held;
        bit done;
        bit waiting;
        exp_n = 0;
        for (int s = 0; s < SLOTS; s++) begin
            ex[s] = 0;
            ey[s] = 0;
        end
        for (int s = 0; s < SLOTS; s++) begin
            if (m_act[s]) begin
                ex[exp_n] = m_x[s];
                ey[exp_n] = m_y[s];
                exp_n++;
            end
        end
        got_n   = 0;
        held    = 0;
        done    = 1'b0;
        waiting = 1'b0;
        draw_start = 1'b1;
        @(negedge clk);
        draw_start = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (inject_tick) frame_tick = (cyc == 1);
            if (waiting) check("hold_valid", 32'(obj_valid), 1);
            waiting = 1'b0;
            if (obj_valid) begin
                if (got_n < exp_n) begin
                    check("beat_x", 32'(obj_x), 32'(ex[got_n]));
                    check("beat_y", 32'(obj_y), 32'(ey[got_n]));
                end else begin
                    check("extra_beat", 32'(got_n + 1), 32'(exp_n));
                end
                if (held < stall) begin
                    obj_ready = 1'b0;
                    held++;
                end else if (stall > 0) begin
                    obj_ready = 1'b1;
                end else begin
                    obj_ready = 1'($urandom_range(0, 1));
                end
                if (obj_ready) got_n++;
                else           waiting = 1'b1;
            end else begin
                obj_ready = 1'($urandom_range(0, 1));
            end
            if (scan_done) begin
                done = 1'b1;
                check("done_valid_low", 32'(obj_valid), 0);
            end else begin
                @(negedge clk);
            end
        end
        frame_tick = 1'b0;
        obj_ready  = 1'b0;
        check("scan_done_seen", 32'(done), 1);
        check("beat_count", 32'(got_n), 32'(exp_n));
        if (inject_tick) begin
            wait_move();
            model_tick();
            check("count_after_scan_tick", 32'(active_count), 32'(model_count()));
        end
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        frame_tick = 1'b0;
        spawn      = 1'b0;
        spawn_y    = '0;
        draw_start = 1'b0;
        obj_ready  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("por");
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        // Single spawn, single beat
        do_spawn(37, 1);
        do_draw(0, 1'b0);

        // Clamp and held spawn level
        do_reset();
        do_spawn(1000, 1000);
        do_draw(0, 1'b0);

        // Table overflow
        do_reset();
        for (int i = 0; i < 5; i++) do_spawn(10 * i + 3, 1);
        check("full_count", 32'(active_count), 32'(SLOTS));

        // Full journey across the screen
        do_reset();
        do_spawn(64, 1);
        for (int i = 0; i < SCREEN_W - 1; i++) do_tick();
        do_draw(0, 1'b0);
        do_tick();
        check("journey_empty", 32'(active_count), 0);

        // Sparse table (slots 1 and 3), stalled drawer, tick during scan
        do_reset();
        do_spawn(5, 1);
        do_spawn(6, 1);
        for (int i = 0; i < 50; i++) do_tick();
        do_spawn(7, 1);
        for (int i = 0; i < 110; i++) do_tick();
        do_spawn(8, 1);
        for (int i = 0; i < 30; i++) do_tick();
        do_spawn(10, 1);
        do_spawn(90, 1);
        for (int i = 0; i < 130; i++) do_tick();
        check("sparse_count", 32'(active_count), 2);
        do_draw(5, 1'b1);

        // enable low ignores events; spawn level held across enable is no edge
        enable = 1'b0;
        frame_tick = 1'b1;
        draw_start = 1'b1;
        spawn      = 1'b1;
        spawn_y    = 10'd50;
        @(negedge clk);
        frame_tick = 1'b0;
        draw_start = 1'b0;
        repeat (3) @(negedge clk);
        check("frozen_busy", 32'(busy), 0);
        check("frozen_count", 32'(active_count), 32'(model_count()));
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("resume_busy", 32'(busy), 0);
        check("resume_count", 32'(active_count), 32'(model_count()));
        spawn = 1'b0;
        @(negedge clk);
        do_draw(0, 1'b0);

        // Random mix
        for (int it = 0; it < 80; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                do_spawn(int'($urandom_range(0, 1023)), int'($urandom_range(1, 3)));
            end else if (op < 8) begin
                int n;
                n = int'($urandom_range(1, 40));
                for (int k = 0; k < n; k++) do_tick();
            end else begin
                do_draw(0, 1'b0);
            end
        end

        // Reset on the second MOVE cycle
        do_spawn(20, 1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int w = 0; w < 10 && !busy; w++) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("mid_move");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("post_reset_count", 32'(active_count), 0);
        do_spawn(55, 1);
        do_draw(0, 1'b0);

`ifdef OBSTACLE_OVF_CNT_EN
        check("ovf_pulses", 32'(pulse_seen), 32'(m_drops_total));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
